// File: rtl/pll_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pll_phase_ctrl_if
// Purpose  : Valid/ready phase-shift request channel into pll_phase_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface pll_phase_ctrl_if #(
    parameter int STEPS_W = 8
);
    logic               req_valid_i;
    logic               req_ready_o;
    logic [1:0]         req_sel_i;
    logic               req_dir_i;
    logic [STEPS_W-1:0] req_steps_i;

    modport master (
        output req_valid_i,
        output req_sel_i,
        output req_dir_i,
        output req_steps_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_sel_i,
        input  req_dir_i,
        input  req_steps_i,
        output req_ready_o
    );
endinterface
`default_nettype wire

// File: rtl/pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pll_phase_ctrl
// Purpose  : PLL lock debounce plus dynamic phase-step sequencer with re-lock
//            timeout, sitting directly downstream of the ECP5 PLL wrapper.
// Revision : 1.0 - initial release
// ============================================================================
module pll_phase_ctrl #(
    parameter int STEP_HIGH_CYCLES    = 4,
    parameter int STEP_GAP_CYCLES     = 4,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65535,
    parameter int STEPS_W             = 8
) (
    input  wire         clk_i,
    input  wire         reset_n_i,
    input  wire         pll_locked_i,
    pll_phase_ctrl_if.slave req,
    output logic [1:0]  phasesel_o,
    output logic        phasedir_o,
    output logic        phasestep_o,
    output logic        phaseloadreg_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        locked_sync_o,
    output logic        clk_ready_o
);

    localparam int c_MAX_A   = (STEP_HIGH_CYCLES > STEP_GAP_CYCLES) ? STEP_HIGH_CYCLES : STEP_GAP_CYCLES;
    localparam int c_MAX_B   = (LOCK_STABLE_CYCLES > LOCK_TIMEOUT_CYCLES) ? LOCK_STABLE_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int c_MAX     = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CNT_W   = $clog2(c_MAX) + 1;

    localparam logic [c_CNT_W-1:0] c_HI_LAST  = c_CNT_W'(STEP_HIGH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'(STEP_GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STABLE   = c_CNT_W'(LOCK_STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [STEPS_W-1:0] c_STEP_ONE = STEPS_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP     = 3'd1,
        S_STEP_HI   = 3'd2,
        S_STEP_LO   = 3'd3,
        S_WAIT_LOCK = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic                 w_timeout;
    logic                 w_xfer;
    logic                 w_counting;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   r_stab_cnt;
    logic [STEPS_W-1:0]   r_steps_left;
    logic [1:0]           r_sel;
    logic                 r_dir;
    logic                 r_step;
    logic                 r_done;
    logic                 r_error;
    logic                 r_timed_out;
    logic                 r_sync1;
    logic                 r_sync2;

    assign req.req_ready_o = (r_state == S_IDLE);
    assign w_xfer          = req.req_valid_i && (r_state == S_IDLE);
    assign w_counting      = (r_state == S_SETUP) || (r_state == S_STEP_HI) ||
                             (r_state == S_STEP_LO) || (r_state == S_WAIT_LOCK);

    assign phasesel_o     = r_sel;
    assign phasedir_o     = r_dir;
    assign phasestep_o    = r_step;
    assign phaseloadreg_o = 1'b0;
    assign busy_o         = (r_state != S_IDLE);
    assign done_o         = r_done;
    assign error_o        = r_error;
    assign locked_sync_o  = r_sync2;
    assign clk_ready_o    = (r_stab_cnt == c_STABLE);

    // Lock synchronizer and saturating stability counter, independent of the FSM
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_stab_cnt <= '0;
        end else begin
            r_sync1 <= pll_locked_i;
            r_sync2 <= r_sync1;
            if (!r_sync2) begin
                r_stab_cnt <= '0;
            end else if (r_stab_cnt != c_STABLE) begin
                r_stab_cnt <= r_stab_cnt + c_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_next_state = (req.req_steps_i == '0) ? S_DONE : S_SETUP;
                end
            end
            S_SETUP: begin
                if (r_cnt == c_GAP_LAST) w_next_state = S_STEP_HI;
            end
            S_STEP_HI: begin
                if (r_cnt == c_HI_LAST) w_next_state = S_STEP_LO;
            end
            S_STEP_LO: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_next_state = (r_steps_left != '0) ? S_STEP_HI : S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (clk_ready_o) begin
                    w_next_state = S_DONE;
                end else if (r_cnt == c_TMO_LAST) begin
                    w_next_state = S_DONE;
                    w_timeout    = 1'b1;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_steps_left <= '0;
            r_sel        <= 2'd0;
            r_dir        <= 1'b0;
            r_step       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_timed_out  <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // One counter serves every timed state; it restarts on each state change
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (w_counting) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end

            if (w_xfer) begin
                r_steps_left <= req.req_steps_i;
                r_sel        <= req.req_sel_i;
                r_dir        <= req.req_dir_i;
            end else if ((r_state == S_STEP_HI) && (w_next_state == S_STEP_LO)) begin
                r_steps_left <= r_steps_left - c_STEP_ONE;
            end

            if (w_xfer) begin
                r_timed_out <= 1'b0;
            end else if (w_timeout) begin
                r_timed_out <= 1'b1;
            end

            // Error rises together with done and stays until the next transfer
            if (w_xfer) begin
                r_error <= 1'b0;
            end else if ((r_state == S_DONE) && r_timed_out) begin
                r_error <= 1'b1;
            end

            r_step <= (r_state == S_STEP_HI);
            r_done <= (r_state == S_DONE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_phase_ctrl
// Purpose  : Directed self-checking bench for pll_phase_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_phase_ctrl;

    localparam int c_N = 160;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic [1:0] phasesel;
    logic       phasedir, phasestep, phaseloadreg, busy, done, error, locked_sync, clk_ready;

    int checks   = 0;
    int failures = 0;
    int n;
    int mism;
    int first;

    logic       st_tr  [0:c_N-1];
    logic       dn_tr  [0:c_N-1];
    logic       er_tr  [0:c_N-1];
    logic       rdy_tr [0:c_N-1];
    logic       dir_tr [0:c_N-1];
    logic [1:0] sel_tr [0:c_N-1];

    pll_phase_ctrl_if #(.STEPS_W(8)) req_if ();

    pll_phase_ctrl #(
        .STEP_HIGH_CYCLES    (4),
        .STEP_GAP_CYCLES     (4),
        .LOCK_STABLE_CYCLES  (16),
        .LOCK_TIMEOUT_CYCLES (100),
        .STEPS_W             (8)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .pll_locked_i   (pll_locked),
        .req            (req_if.slave),
        .phasesel_o     (phasesel),
        .phasedir_o     (phasedir),
        .phasestep_o    (phasestep),
        .phaseloadreg_o (phaseloadreg),
        .busy_o         (busy),
        .done_o         (done),
        .error_o        (error),
        .locked_sync_o  (locked_sync),
        .clk_ready_o    (clk_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_req(input int sel, input int dir, input int steps);
        req_if.req_valid_i = 1'b1;
        req_if.req_sel_i   = 2'(sel);
        req_if.req_dir_i   = 1'(dir);
        req_if.req_steps_i = 8'(steps);
    endtask

    // Sample k is taken on the falling edge after rising edge k (k=0: first edge after the call)
    task automatic run(input int ncyc, input int drop_k);
        for (int i = 0; i < c_N; i++) begin
            st_tr[i] = 1'b0; dn_tr[i] = 1'b0; er_tr[i] = 1'b0;
            rdy_tr[i] = 1'b0; dir_tr[i] = 1'b0; sel_tr[i] = 2'd0;
        end
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            st_tr[k]  = phasestep;
            dn_tr[k]  = done;
            er_tr[k]  = error;
            rdy_tr[k] = req_if.req_ready_o;
            sel_tr[k] = phasesel;
            dir_tr[k] = phasedir;
            if (k == drop_k) req_if.req_valid_i = 1'b0;
        end
    endtask

    function automatic int first_done(input int from);
        for (int k = from; k < c_N; k++) if (dn_tr[k]) return k;
        return -1;
    endfunction

    function automatic int count_rises(input int a, input int b);
        int cnt = 0;
        for (int k = a; k <= b; k++) if (st_tr[k] && (k == 0 || !st_tr[k-1])) cnt++;
        return cnt;
    endfunction

    initial begin
        reset_n            = 1'b0;
        pll_locked         = 1'b1;
        req_if.req_valid_i = 1'b0;
        req_if.req_sel_i   = 2'd0;
        req_if.req_dir_i   = 1'b0;
        req_if.req_steps_i = 8'd0;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ready", int'(req_if.req_ready_o), 1);
        chk("rst_outs", int'({phasesel, phasedir, phasestep, phaseloadreg, busy,
                              done, error, locked_sync, clk_ready}), 0);

        // Lock synchronizer latency, then stability window
        reset_n = 1'b1;
        n = 0;
        while (!locked_sync && n < 10) begin @(negedge clk); n++; end
        chk("sync_lat_2to3", int'(n >= 2 && n <= 3), 1);
        chk("ready_before_stable", int'(clk_ready), 0);
        n = 0;
        while (!clk_ready && n < 40) begin @(negedge clk); n++; end
        chk("stable_cycles", n, 16);

        // One-cycle lock glitch
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        n = 0;
        while (locked_sync && n < 6) begin @(negedge clk); n++; end
        chk("glitch_sync_low", int'(locked_sync), 0);
        n = 0;
        while (!locked_sync && n < 6) begin @(negedge clk); n++; end
        chk("glitch_ready_fell", int'(clk_ready), 0);
        n = 0;
        while (!clk_ready && n < 40) begin @(negedge clk); n++; end
        chk("glitch_restable", n, 16);

        // Basic request: sel=2 dir=1 steps=3; pulses high after edges 5-8, 13-16, 21-24
        drive_req(2, 1, 3);
        run(40, 0);
        mism = 0;
        for (int k = 0; k < 40; k++)
            if (st_tr[k] !== ((k >= 5 && k <= 28 && ((k - 5) % 8) < 4) ? 1'b1 : 1'b0)) mism++;
        chk("basic_step_wave", mism, 0);
        chk("basic_pulse_cnt", count_rises(0, 39), 3);
        chk("basic_done_lat", first_done(0), 30);
        chk("basic_done_once", first_done(31), -1);
        mism = 0;
        for (int k = 0; k <= 30; k++) if (sel_tr[k] !== 2'd2 || dir_tr[k] !== 1'b1) mism++;
        chk("basic_seldir_stable", mism, 0);
        chk("basic_error", int'(er_tr[30]), 0);
        chk("basic_busy_ready", int'(rdy_tr[5]), 0);
        chk("basic_ready_back", int'(rdy_tr[31]), 1);

        // Zero steps
        drive_req(1, 0, 0);
        run(4, 0);
        chk("zero_ready_low", int'(rdy_tr[0]), 0);
        chk("zero_done", int'(dn_tr[1]), 1);
        chk("zero_ready_back", int'(rdy_tr[1]), 1);
        chk("zero_done_pulse", int'(dn_tr[2]), 0);
        chk("zero_no_step", count_rises(0, 3), 0);

        // Timeout: lock lost, steps=1 -> WAIT_LOCK entered at edge 12, done at edge 113
        pll_locked = 1'b0;
        n = 0;
        while (clk_ready && n < 10) begin @(negedge clk); n++; end
        chk("tmo_ready_low", int'(clk_ready), 0);
        drive_req(1, 0, 1);
        run(120, 0);
        chk("tmo_pulse_cnt", count_rises(0, 119), 1);
        chk("tmo_done_lat", first_done(0), 113);
        chk("tmo_err_before", int'(er_tr[112]), 0);
        chk("tmo_err_with_done", int'(er_tr[113]), 1);
        chk("tmo_err_sticky", int'(er_tr[118]), 1);
        chk("tmo_sel", int'(sel_tr[60]), 1);

        pll_locked = 1'b1;
        n = 0;
        while (!clk_ready && n < 40) begin @(negedge clk); n++; end
        chk("tmo_relock", int'(clk_ready), 1);
        chk("tmo_err_held", int'(error), 1);
        drive_req(0, 0, 0);
        run(3, 0);
        chk("tmo_err_cleared", int'(er_tr[0]), 0);

        // Back-pressure: A (sel=3,dir=0,steps=1) accepted; B held valid while busy
        drive_req(3, 0, 1);
        @(negedge clk);
        chk("bp_a_sel", int'(phasesel), 3);
        drive_req(1, 1, 2);
        run(44, 14);                       // sample k here is after edge k+1
        chk("bp_a_done", first_done(0), 13);
        chk("bp_sel_held", int'(sel_tr[12]), 3);
        chk("bp_ready_idle", int'(rdy_tr[13]), 1);
        chk("bp_b_sel", int'(sel_tr[14]), 1);
        chk("bp_b_dir", int'(dir_tr[14]), 1);
        chk("bp_b_pulses", count_rises(14, 43), 2);
        chk("bp_b_done", first_done(14), 36);

        // Reset while phasestep is high
        drive_req(0, 1, 2);
        run(7, 0);
        chk("rst_mid_step_high", int'(st_tr[6]), 1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_step_drop", int'(phasestep), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_ready", int'(req_if.req_ready_o), 1);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run(12, -1);
        chk("rst_after_no_step", count_rises(0, 11), 0);
        chk("rst_after_ready", int'(rdy_tr[11]), 1);
        chk("rst_after_no_done", first_done(0), -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
